// File: rtl/cu_sequencer_if.sv
// Handshake bundle between the control unit and the accumulator CPU datapath.
// The DUT takes the slave side; the environment takes the master side.
interface cu_sequencer_if #(
   parameter int OPW  = 8,
   parameter int CNTW = 16
);
   logic            start;
   logic [OPW-1:0]  ir_opcode;
   logic            acc_neg;
   logic            mem_ready;
   logic [15:0]     ctrl;
   logic            halted;
   logic [CNTW-1:0] retired;
   logic [3:0]      state_dbg;

   modport master (
      output start, ir_opcode, acc_neg, mem_ready,
      input  ctrl, halted, retired, state_dbg
   );

   modport slave (
      input  start, ir_opcode, acc_neg, mem_ready,
      output ctrl, halted, retired, state_dbg
   );
endinterface

// File: rtl/cu_sequencer.sv
// Control unit for the accumulator CPU: fetch/decode/execute sequencing,
// control word generation and retired-instruction counting.
module cu_sequencer #(
   parameter int OPW  = 8,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   cu_sequencer_if.slave   bus
);
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_F1   = 4'd1,
      S_F2   = 4'd2,
      S_F3   = 4'd3,
      S_DEC  = 4'd4,
      S_RD   = 4'd5,
      S_OP   = 4'd6,
      S_ALU  = 4'd7,
      S_ST1  = 4'd8,
      S_ST2  = 4'd9,
      S_HALT = 4'd10
   } state_t;

   localparam logic [OPW-1:0] OP_STORE  = OPW'(8'h01);
   localparam logic [OPW-1:0] OP_LOAD   = OPW'(8'h02);
   localparam logic [OPW-1:0] OP_ADD    = OPW'(8'h03);
   localparam logic [OPW-1:0] OP_SUB    = OPW'(8'h04);
   localparam logic [OPW-1:0] OP_JMPGEZ = OPW'(8'h05);
   localparam logic [OPW-1:0] OP_JMP    = OPW'(8'h06);
   localparam logic [OPW-1:0] OP_HALT   = OPW'(8'h07);
   localparam logic [OPW-1:0] OP_AND    = OPW'(8'h0A);
   localparam logic [OPW-1:0] OP_OR     = OPW'(8'h0B);
   localparam logic [OPW-1:0] OP_NOT    = OPW'(8'h0C);

   state_t          r_state;
   state_t          w_next;
   logic [OPW-1:0]  r_opcode;
   logic [CNTW-1:0] r_retired;
   logic [15:0]     w_ctrl;
   logic            w_retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Later states decode from this copy so IR may change once DEC is past.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opcode <= '0;
      end else if (r_state == S_DEC) begin
         r_opcode <= bus.ir_opcode;
      end else begin
         r_opcode <= r_opcode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNTW'(1);
      end else begin
         r_retired <= r_retired;
      end
   end

   // DEC decodes the live IR because the latched copy only lands at the end of DEC.
   always_comb begin
      w_next   = r_state;
      w_ctrl   = 16'h0000;
      w_retire = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_F1;
            else           w_next = S_IDLE;
         end
         S_F1: begin
            w_ctrl[1] = 1'b1;
            w_next    = S_F2;
         end
         S_F2: begin
            w_ctrl[2] = 1'b1;
            if (bus.mem_ready) begin
               w_ctrl[0] = 1'b1;
               w_next    = S_F3;
            end else begin
               w_next    = S_F2;
            end
         end
         S_F3: begin
            w_ctrl[3] = 1'b1;
            w_next    = S_DEC;
         end
         S_DEC: begin
            case (bus.ir_opcode)
               OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  w_ctrl[4] = 1'b1;
                  w_next    = S_RD;
               end
               OP_STORE: begin
                  w_ctrl[4] = 1'b1;
                  w_next    = S_ST1;
               end
               OP_NOT: w_next = S_ALU;
               OP_HALT: begin
                  w_next   = S_HALT;
                  w_retire = 1'b1;
               end
               OP_JMP: begin
                  w_ctrl[11] = 1'b1;
                  w_next     = S_F1;
                  w_retire   = 1'b1;
               end
               OP_JMPGEZ: begin
                  w_ctrl[11] = ~bus.acc_neg;
                  w_next     = S_F1;
                  w_retire   = 1'b1;
               end
               default: begin
                  w_next   = S_F1;
                  w_retire = 1'b1;
               end
            endcase
         end
         S_RD: begin
            w_ctrl[2] = 1'b1;
            if (bus.mem_ready) w_next = S_OP;
            else               w_next = S_RD;
         end
         S_OP: begin
            w_ctrl[7] = 1'b1;
            w_next    = S_ALU;
         end
         S_ALU: begin
            case (r_opcode)
               OP_LOAD: w_ctrl[15] = 1'b1;
               OP_ADD:  w_ctrl[9]  = 1'b1;
               OP_SUB:  w_ctrl[10] = 1'b1;
               OP_AND:  w_ctrl[12] = 1'b1;
               OP_OR:   w_ctrl[13] = 1'b1;
               OP_NOT:  w_ctrl[14] = 1'b1;
               default: w_ctrl     = 16'h0000;
            endcase
            w_next   = S_F1;
            w_retire = 1'b1;
         end
         S_ST1: begin
            w_ctrl[6] = 1'b1;
            w_next    = S_ST2;
         end
         S_ST2: begin
            w_ctrl[5] = 1'b1;
            if (bus.mem_ready) begin
               w_next   = S_F1;
               w_retire = 1'b1;
            end else begin
               w_next   = S_ST2;
            end
         end
         S_HALT: begin
            if (bus.start) w_next = S_F1;
            else           w_next = S_HALT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.ctrl      = w_ctrl;
   assign bus.halted    = (r_state == S_IDLE) || (r_state == S_HALT);
   assign bus.retired   = r_retired;
   assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: per-cycle state/ctrl/retired/halted checks
// plus a narrow-counter instance that exercises retired wrap-around.
module tb_cu_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cu_sequencer_if #(.OPW(8), .CNTW(16)) bus ();
   cu_sequencer_if #(.OPW(8), .CNTW(4))  wbus ();

   cu_sequencer #(.OPW(8), .CNTW(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   cu_sequencer #(.OPW(8), .CNTW(4))  u_wrap (.clk(clk), .rst(rst), .bus(wbus));

   assign wbus.ir_opcode = 8'hFF;
   assign wbus.acc_neg   = 1'b0;
   assign wbus.mem_ready = 1'b1;

   task automatic chk(input string tag, input logic [3:0] es, input logic [15:0] ec,
                      input logic [15:0] er);
      logic eh;
      eh = (es == 4'd0) || (es == 4'd10);
      checks++;
      assert (bus.state_dbg === es) else begin
         errors++;
         $error("FAIL %s state got %0d exp %0d", tag, bus.state_dbg, es);
      end
      checks++;
      assert (bus.ctrl === ec) else begin
         errors++;
         $error("FAIL %s ctrl got %h exp %h", tag, bus.ctrl, ec);
      end
      checks++;
      assert (bus.retired === er) else begin
         errors++;
         $error("FAIL %s retired got %h exp %h", tag, bus.retired, er);
      end
      checks++;
      assert (bus.halted === eh) else begin
         errors++;
         $error("FAIL %s halted got %b exp %b", tag, bus.halted, eh);
      end
   endtask

   task automatic cyc(input string tag, input logic st, input logic [7:0] ir, input logic an,
                      input logic mr, input logic [3:0] es, input logic [15:0] ec,
                      input logic [15:0] er);
      @(negedge clk);
      bus.start     = st;
      bus.ir_opcode = ir;
      bus.acc_neg   = an;
      bus.mem_ready = mr;
      #1;
      chk(tag, es, ec, er);
   endtask

   task automatic fetch(input string tag, input logic [15:0] er);
      cyc({tag, "_f1"}, 1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 16'h0002, er);
      cyc({tag, "_f2"}, 1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 16'h0005, er);
      cyc({tag, "_f3"}, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 16'h0008, er);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.ir_opcode = 8'h00;
      bus.acc_neg   = 1'b0;
      bus.mem_ready = 1'b0;
      wbus.start    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset", 4'd0, 16'h0000, 16'h0000);
      rst = 1'b0;

      // LOAD, IR scrambled after DEC
      cyc("idle_start", 1'b1, 8'h00, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000);
      fetch("ld", 16'h0000);
      cyc("ld_dec", 1'b0, 8'h02, 1'b0, 1'b1, 4'd4, 16'h0010, 16'h0000);
      cyc("ld_rd",  1'b0, 8'h07, 1'b0, 1'b1, 4'd5, 16'h0004, 16'h0000);
      cyc("ld_op",  1'b0, 8'h07, 1'b0, 1'b1, 4'd6, 16'h0080, 16'h0000);
      cyc("ld_alu", 1'b0, 8'h07, 1'b0, 1'b1, 4'd7, 16'h8000, 16'h0000);

      // ADD with F2 stall and 3-cycle RD stall
      cyc("add_f1",   1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 16'h0002, 16'h0001);
      cyc("add_f2w",  1'b0, 8'h00, 1'b0, 1'b0, 4'd2, 16'h0004, 16'h0001);
      cyc("add_f2",   1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 16'h0005, 16'h0001);
      cyc("add_f3",   1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 16'h0008, 16'h0001);
      cyc("add_dec",  1'b0, 8'h03, 1'b0, 1'b1, 4'd4, 16'h0010, 16'h0001);
      for (int i = 0; i < 3; i++)
         cyc("add_rdw", 1'b0, 8'h03, 1'b0, 1'b0, 4'd5, 16'h0004, 16'h0001);
      cyc("add_rd",   1'b0, 8'h03, 1'b0, 1'b1, 4'd5, 16'h0004, 16'h0001);
      cyc("add_op",   1'b0, 8'h03, 1'b0, 1'b0, 4'd6, 16'h0080, 16'h0001);
      cyc("add_alu",  1'b0, 8'h03, 1'b0, 1'b0, 4'd7, 16'h0200, 16'h0001);

      // JMPGEZ taken and not taken
      fetch("jg0", 16'h0002);
      cyc("jg0_dec", 1'b0, 8'h05, 1'b0, 1'b1, 4'd4, 16'h0800, 16'h0002);
      fetch("jg1", 16'h0003);
      cyc("jg1_dec", 1'b0, 8'h05, 1'b1, 1'b1, 4'd4, 16'h0000, 16'h0003);

      // STORE with 2-cycle ST2 stall
      fetch("st", 16'h0004);
      cyc("st_dec",  1'b0, 8'h01, 1'b0, 1'b1, 4'd4, 16'h0010, 16'h0004);
      cyc("st_st1",  1'b0, 8'h01, 1'b0, 1'b0, 4'd8, 16'h0040, 16'h0004);
      cyc("st_st2a", 1'b0, 8'h01, 1'b0, 1'b0, 4'd9, 16'h0020, 16'h0004);
      cyc("st_st2b", 1'b0, 8'h01, 1'b0, 1'b0, 4'd9, 16'h0020, 16'h0004);
      cyc("st_st2c", 1'b0, 8'h01, 1'b0, 1'b1, 4'd9, 16'h0020, 16'h0004);

      // NOT goes straight to ALU
      fetch("not", 16'h0005);
      cyc("not_dec", 1'b0, 8'h0C, 1'b0, 1'b1, 4'd4, 16'h0000, 16'h0005);
      cyc("not_alu", 1'b0, 8'h0C, 1'b0, 1'b1, 4'd7, 16'h4000, 16'h0005);

      // Unknown opcode runs as NOP
      fetch("nop", 16'h0006);
      cyc("nop_dec", 1'b0, 8'hFF, 1'b0, 1'b1, 4'd4, 16'h0000, 16'h0006);

      // HALT parks, start restarts
      fetch("hlt", 16'h0007);
      cyc("hlt_dec", 1'b0, 8'h07, 1'b0, 1'b1, 4'd4, 16'h0000, 16'h0007);
      for (int i = 0; i < 3; i++)
         cyc("hlt_park", 1'b0, 8'h07, 1'b0, 1'b1, 4'd10, 16'h0000, 16'h0008);
      cyc("hlt_start", 1'b1, 8'h07, 1'b0, 1'b1, 4'd10, 16'h0000, 16'h0008);

      // Reset in the middle of a stalled RD
      cyc("rs_f1",  1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 16'h0002, 16'h0008);
      cyc("rs_f2",  1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 16'h0005, 16'h0008);
      cyc("rs_f3",  1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 16'h0008, 16'h0008);
      cyc("rs_dec", 1'b0, 8'h02, 1'b0, 1'b1, 4'd4, 16'h0010, 16'h0008);
      cyc("rs_rd",  1'b0, 8'h02, 1'b0, 1'b0, 4'd5, 16'h0004, 16'h0008);
      rst = 1'b1;
      #1;
      chk("rs_async", 4'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      cyc("rs_idle",  1'b0, 8'h02, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000);
      cyc("rs_start", 1'b1, 8'h02, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000);
      cyc("rs_go",    1'b0, 8'h02, 1'b0, 1'b1, 4'd1, 16'h0002, 16'h0000);

      // Narrow counter wrap: 15 NOPs to all-ones, one more to zero
      @(negedge clk);
      wbus.start = 1'b1;
      @(negedge clk);
      wbus.start = 1'b0;
      repeat (60) @(negedge clk);
      #1;
      checks++;
      assert (wbus.retired === 4'hF && wbus.state_dbg === 4'd1) else begin
         errors++;
         $error("FAIL wrap_max retired got %h state %0d exp F state 1", wbus.retired, wbus.state_dbg);
      end
      repeat (4) @(negedge clk);
      #1;
      checks++;
      assert (wbus.retired === 4'h0 && wbus.state_dbg === 4'd1) else begin
         errors++;
         $error("FAIL wrap_zero retired got %h state %0d exp 0 state 1", wbus.retired, wbus.state_dbg);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
